// File: rtl/sad_pkg.sv
// Shared types and default sizing for the sum-of-absolute-differences engine.
package sad_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } sad_state_t;

    localparam int SAD_DATA_W  = 8;
    localparam int SAD_OUT_W   = 32;
    localparam int SAD_NUM_PIX = 255;

    // The counter must be able to hold NUM_PIX itself after the final increment.
    function automatic int cnt_width(input int num_pix);
        return $clog2(num_pix + 1);
    endfunction

endpackage

// File: rtl/sad_unit_abs_diff.sv
// Combinational |a-b| for unsigned pixels; the magnitude always fits in DATA_W bits.
module abs_diff #(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] diff
);

    // Subtract the smaller from the larger so no borrow ever reaches the result.
    assign diff = (a >= b) ? (a - b) : (b - a);

endmodule

// File: rtl/sad_unit.sv
// Block SAD accumulator: IDLE waits for enb_i, RUN sums NUM_PIX pixel pairs,
// DONE publishes the total on dt_o and returns to IDLE.
module sad_unit
    import sad_pkg::*;
#(
    parameter int NUM_PIX = SAD_NUM_PIX,
    parameter int DATA_W  = SAD_DATA_W,
    parameter int OUT_W   = SAD_OUT_W
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              enb_i,
    input  logic [DATA_W-1:0] dta_i,
    input  logic [DATA_W-1:0] dtb_i,
    output logic              busy_o,
    output logic [OUT_W-1:0]  dt_o
);

    localparam int CNT_W = cnt_width(NUM_PIX);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_PIX - 1);

    sad_state_t        state_reg;
    sad_state_t        state_next;
    logic [CNT_W-1:0]  cnt_reg;
    logic [OUT_W-1:0]  acc_reg;
    logic [OUT_W-1:0]  dt_reg;
    logic              busy_reg;
    logic [DATA_W-1:0] diff;

    abs_diff #(
        .DATA_W(DATA_W)
    ) u_abs_diff (
        .a   (dta_i),
        .b   (dtb_i),
        .diff(diff)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            busy_reg  <= (state_next != IDLE);
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (enb_i) state_next = RUN;
            RUN:     if (cnt_reg == LAST_CNT) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Clearing on IDLE->RUN keeps consecutive blocks independent.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_reg <= '0;
            acc_reg <= '0;
            dt_reg  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (enb_i) begin
                        cnt_reg <= '0;
                        acc_reg <= '0;
                    end
                end
                RUN: begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                    acc_reg <= acc_reg + OUT_W'(diff);
                end
                DONE: dt_reg <= acc_reg;
                default: ;
            endcase
        end
    end

    assign busy_o = busy_reg;
    assign dt_o   = dt_reg;

endmodule

// File: tb/tb_sad_unit.sv
// Self-checking bench for sad_unit: block-level SAD model plus per-cycle output compare.
module tb_sad_unit;
    import sad_pkg::*;

    localparam int N = SAD_NUM_PIX;
    localparam int NUM_RANDOM_BLOCKS = 250;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enb = 1'b0;
    logic [7:0]  dta = '0;
    logic [7:0]  dtb = '0;
    logic        busy;
    logic [31:0] dt;

    logic        exp_busy = 1'b0;
    logic [31:0] exp_dt = '0;
    int          checks = 0;
    int          fails = 0;

    logic [7:0]  pa [N];
    logic [7:0]  pb [N];

    sad_unit dut (
        .clk_i  (clk),
        .rst_n_i(rst_n),
        .enb_i  (enb),
        .dta_i  (dta),
        .dtb_i  (dtb),
        .busy_o (busy),
        .dt_o   (dt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Outputs are meaningful every cycle, including during reset.
    always @(negedge clk) begin
        check("busy_o", {31'd0, busy}, {31'd0, exp_busy});
        check("dt_o", dt, exp_dt);
    end

    function automatic int model_sad();
        int s = 0;
        for (int i = 0; i < N; i++) begin
            int d = int'(pa[i]) - int'(pb[i]);
            s += (d < 0) ? -d : d;
        end
        return s;
    endfunction

    // Entered at posedge+1 with the DUT in IDLE and enb already high.
    task automatic run_block(input int abort_after, input longint lit, input string name);
        int sum;
        sum = model_sad();
        if (lit >= 0) check({"model_", name}, 32'(sum), 32'(lit));
        @(posedge clk); #1;
        exp_busy = 1'b1;
        dta = pa[0];
        dtb = pb[0];
        for (int k = 0; k < N; k++) begin
            @(posedge clk); #1;
            if (k == abort_after) begin
                #2;
                rst_n = 1'b0;
                enb = 1'b0;
                exp_busy = 1'b0;
                exp_dt = '0;
                #1;
                check("async_rst_busy", {31'd0, busy}, 32'd0);
                check("async_rst_dt", dt, 32'd0);
                return;
            end
            if (k < N - 1) begin
                dta = pa[k+1];
                dtb = pb[k+1];
            end
        end
        @(posedge clk); #1;
        exp_busy = 1'b0;
        exp_dt = 32'(sum);
        $display("block %s: sad=%0d dt_o=%0d", name, sum, dt);
        if (lit >= 0) check(name, dt, 32'(lit));
    endtask

    task automatic fill_const(input logic [7:0] a, input logic [7:0] b);
        for (int i = 0; i < N; i++) begin
            pa[i] = a;
            pb[i] = b;
        end
    endtask

    initial begin
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            dta = 8'($urandom);
            dtb = 8'($urandom);
            enb = 1'($urandom);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        enb = 1'b1;

        fill_const(8'd10, 8'd3);
        run_block(-1, 1785, "const_10_3");
        fill_const(8'd0, 8'd255);
        run_block(-1, 65025, "extreme_0_255");
        fill_const(8'd255, 8'd0);
        run_block(-1, 65025, "extreme_255_0");
        for (int i = 0; i < N; i++) begin
            pa[i] = 8'($urandom);
            pb[i] = pa[i];
        end
        run_block(-1, 0, "equal");

        for (int blk = 0; blk < NUM_RANDOM_BLOCKS; blk++) begin
            for (int i = 0; i < N; i++) begin
                pa[i] = 8'($urandom);
                pb[i] = 8'($urandom);
            end
            run_block(-1, -1, $sformatf("random_%0d", blk));
        end

        for (int i = 0; i < N; i++) begin
            pa[i] = 8'($urandom_range(1, 255));
            pb[i] = 8'd0;
        end
        run_block(100, -1, "aborted");
        @(posedge clk); #1;
        rst_n = 1'b1;
        enb = 1'b1;
        fill_const(8'd1, 8'd0);
        run_block(-1, 255, "after_abort");

        enb = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
